fifo_rd_serializer: RTL and testbench

Read-side companion for the team's synchronous FIFO: pops one DATA_WIDTH word at a time from the FIFO read port and serializes it MSB-first onto a 1-bit valid/ready stream. It sits between a FIFO instance and a bit-serial downstream consumer, owning `rd_en` and honouring the FIFO's one-cycle registered `dout` latency.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/piso_shift.sv | 46 ++++
 rtl/fifo_rd_serializer.sv | 93 +++++++++
 tb/tb_fifo_rd_serializer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared state encoding and parameter defaults for the FIFO read-side serializer.
package fifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      POP   = 2'd1,
      LOAD  = 2'd2,
      SHIFT = 2'd3
   } rd_state_e;

   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned CNT_WIDTH_DEF  = 16;

   // Bits needed to index 0..w-1; never less than one bit.
   function automatic int unsigned bit_cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in/serial-out shifter, MSB first, with a bit counter flagging the final bit.
module piso_shift
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             shift_i,
   output logic             msb_o,
   output logic             last_o
);

   localparam int unsigned CB = bit_cnt_width(WIDTH);

   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CB-1:0]    cnt_q,   cnt_d;

   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         shreg_d = din_i;
         cnt_d   = '0;
      end else if (shift_i) begin
         shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
         cnt_d   = cnt_q + CB'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign msb_o  = shreg_q[WIDTH-1];
   assign last_o = (cnt_q == CB'(WIDTH - 1));

endmodule

// File: rtl/fifo_rd_serializer.sv
// Pops words from a synchronous FIFO (registered dout) and streams them MSB-first
// over a 1-bit valid/ready interface; owns rd_en and counts completed words.
module fifo_rd_serializer
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  rd_en,
   output logic                  ser_data,
   output logic                  ser_valid,
   input  logic                  ser_ready,
   output logic                  ser_last,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  words_sent
);

   rd_state_e            state_q, state_d;
   logic                 rd_en_q, rd_en_d;
   logic [CNT_WIDTH-1:0] words_q, words_d;
   logic                 load;
   logic                 shift;
   logic                 bit_msb;
   logic                 bit_last;

   piso_shift #(
      .WIDTH (DATA_WIDTH)
   ) u_piso (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .load_i  (load),
      .din_i   (fifo_dout),
      .shift_i (shift),
      .msb_o   (bit_msb),
      .last_o  (bit_last)
   );

   always_comb begin
      state_d = state_q;
      words_d = words_q;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable && !fifo_empty) state_d = POP;
         end
         POP: begin
            state_d = LOAD;
         end
         LOAD: begin
            load    = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (ser_ready) begin
               shift = 1'b1;
               if (bit_last) begin
                  state_d = IDLE;
                  words_d = words_q + CNT_WIDTH'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Pop strobe is registered so it is high for exactly the POP cycle.
      rd_en_d = (state_d == POP);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rd_en_q <= 1'b0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         rd_en_q <= rd_en_d;
         words_q <= words_d;
      end
   end

   assign rd_en      = rd_en_q;
   assign ser_valid  = (state_q == SHIFT);
   assign ser_data   = bit_msb;
   assign ser_last   = (state_q == SHIFT) && bit_last;
   assign busy       = (state_q != IDLE);
   assign words_sent = words_q;

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Directed bench for fifo_rd_serializer with behavioural FIFO models and a bit monitor.
module tb_fifo_rd_serializer;

   logic        clk = 1'b0;
   logic        reset_n;

   logic        enable, ser_ready;
   logic        fifo_empty = 1'b1;
   logic [7:0]  fifo_dout  = '0;
   logic        rd_en, ser_data, ser_valid, ser_last, busy;
   logic [15:0] words_sent;

   logic        enable2, ser_ready2;
   logic        fifo_empty2 = 1'b1;
   logic [7:0]  fifo_dout2  = '0;
   logic        rd_en2, ser_data2, ser_valid2, ser_last2, busy2;
   logic [1:0]  words_sent2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fifo_rd_serializer #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_dout(fifo_dout), .rd_en(rd_en), .ser_data(ser_data), .ser_valid(ser_valid),
      .ser_ready(ser_ready), .ser_last(ser_last), .busy(busy), .words_sent(words_sent)
   );

   fifo_rd_serializer #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .enable(enable2), .fifo_empty(fifo_empty2),
      .fifo_dout(fifo_dout2), .rd_en(rd_en2), .ser_data(ser_data2), .ser_valid(ser_valid2),
      .ser_ready(ser_ready2), .ser_last(ser_last2), .busy(busy2), .words_sent(words_sent2)
   );

   // Synchronous FIFO models: registered dout and registered empty flag.
   logic [7:0] q1[$];
   logic [7:0] q2[$];
   logic       push1_v = 1'b0, push2_v = 1'b0;
   logic [7:0] push1_d = '0,   push2_d = '0;
   int         pop_empty_cnt = 0;

   always @(posedge clk) begin
      if (rd_en) begin
         if (q1.size() != 0) fifo_dout <= q1.pop_front();
         else pop_empty_cnt <= pop_empty_cnt + 1;
      end
      if (push1_v) q1.push_back(push1_d);
      fifo_empty <= (q1.size() == 0);
   end

   always @(posedge clk) begin
      if (rd_en2) begin
         if (q2.size() != 0) fifo_dout2 <= q2.pop_front();
         else pop_empty_cnt <= pop_empty_cnt + 1;
      end
      if (push2_v) q2.push_back(push2_d);
      fifo_empty2 <= (q2.size() == 0);
   end

   // Monitor samples late in each cycle, after inputs settle and before the next edge.
   logic mbits[$];
   logic mlasts[$];
   int   mbc[$];
   int   mrd[$];
   int   mcyc = 0, vcnt = 0, stall_viol = 0;
   logic prev_stall = 1'b0, prev_data = 1'b0;

   always begin
      @(negedge clk);
      #3;
      mcyc = mcyc + 1;
      if (rd_en) mrd.push_back(mcyc);
      if (ser_valid) vcnt = vcnt + 1;
      if (ser_valid && ser_ready) begin
         mbits.push_back(ser_data);
         mlasts.push_back(ser_last);
         mbc.push_back(mcyc);
      end
      if (prev_stall && ser_valid && (ser_data != prev_data)) stall_viol = stall_viol + 1;
      prev_stall = ser_valid && !ser_ready;
      prev_data  = ser_data;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push1(input logic [7:0] d);
      push1_v = 1'b1; push1_d = d;
      tick(1);
      push1_v = 1'b0;
   endtask

   task automatic push2(input logic [7:0] d);
      push2_v = 1'b1; push2_d = d;
      tick(1);
      push2_v = 1'b0;
   endtask

   task automatic wait_words1(input string tag, input logic [15:0] target, input int budget);
      int n = 0;
      while (words_sent != target && n < budget) begin
         tick(1);
         n++;
      end
      check_eq(tag, words_sent, target);
   endtask

   task automatic wait_rd1(input string tag, input int budget);
      int n = 0;
      while (!rd_en && n < budget) begin
         tick(1);
         n++;
      end
      check_eq(tag, rd_en, 1);
   endtask

   task automatic check_word(input string tag, input int idx, input logic [7:0] exp);
      logic [7:0] w  = '0;
      logic [7:0] lm = '0;
      for (int i = 0; i < 8; i++) begin
         if (idx + i < mbits.size()) begin
            w  = {w[6:0], mbits[idx+i]};
            lm = {lm[6:0], mlasts[idx+i]};
         end else begin
            w  = {w[6:0], 1'bx};
            lm = {lm[6:0], 1'bx};
         end
      end
      check_eq({tag, "_bits"}, w, exp);
      check_eq({tag, "_last"}, lm, 8'h01);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_rd_en"}, rd_en, 0);
      check_eq({tag, "_data"},  ser_data, 0);
      check_eq({tag, "_valid"}, ser_valid, 0);
      check_eq({tag, "_last"},  ser_last, 0);
      check_eq({tag, "_busy"},  busy, 0);
      check_eq({tag, "_words"}, words_sent, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b, r, v0, i;
      logic [1:0] seq[$];
      logic [1:0] prev2;

      reset_n = 1'b0; enable = 1'b1; ser_ready = 1'b1;
      enable2 = 1'b0; ser_ready2 = 1'b1;
      tick(2);

      // Word A5 straight out of reset
      push1(8'hA5);
      check_reset_vals("rst");
      b = mbits.size(); r = mrd.size();
      reset_n = 1'b1;
      wait_words1("a5_done", 16'd1, 30);
      check_eq("a5_npop", mrd.size() - r, 1);
      check_word("a5", b, 8'hA5);
      check_eq("a5_lat_first", mbc[b] - mrd[r], 2);
      check_eq("a5_lat_last", mbc[b+7] - mrd[r], 9);
      check_eq("a5_busy_after", busy, 0);

      // 3C with ready alternating, first SHIFT cycle stalled
      b = mbits.size();
      push1(8'h3C);
      wait_rd1("3c_rd", 10);
      v0 = vcnt; i = 0;
      while (words_sent != 16'd2 && i < 40) begin
         ser_ready = i[0];
         tick(1);
         i++;
      end
      ser_ready = 1'b1;
      check_eq("3c_done", words_sent, 2);
      check_eq("3c_shift_cycles", vcnt - v0, 16);
      check_word("3c", b, 8'h3C);
      check_eq("3c_stall_stable", stall_viol, 0);

      // Four queued words with continuous ready
      b = mbits.size(); r = mrd.size();
      push1(8'h11); push1(8'h22); push1(8'h33); push1(8'h44);
      wait_words1("q4_done", 16'd6, 80);
      tick(20);
      check_eq("q4_npop", mrd.size() - r, 4);
      for (int k = 1; k < 4; k++) check_eq($sformatf("q4_space%0d", k), mrd[r+k] - mrd[r+k-1], 11);
      check_word("q4_w0", b,      8'h11);
      check_word("q4_w1", b + 8,  8'h22);
      check_word("q4_w2", b + 16, 8'h33);
      check_word("q4_w3", b + 24, 8'h44);
      check_eq("q4_words", words_sent, 6);

      // enable dropped mid-word, then re-raised
      enable = 1'b0;
      b = mbits.size(); r = mrd.size();
      push1(8'h55); push1(8'h66);
      tick(3);
      check_eq("en_off_nopop", mrd.size() - r, 0);
      enable = 1'b1;
      wait_rd1("en_rd", 5);
      tick(5);
      check_eq("en_mid_valid", ser_valid, 1);
      enable = 1'b0;
      wait_words1("en_w1_done", 16'd7, 30);
      tick(15);
      check_eq("en_npop", mrd.size() - r, 1);
      check_eq("en_idle_busy", busy, 0);
      check_word("en_w1", b, 8'h55);
      enable = 1'b1;
      tick(1);
      check_eq("en_pop_next", rd_en, 1);
      wait_words1("en_w2_done", 16'd8, 30);
      check_word("en_w2", b + 8, 8'h66);

      // Asynchronous reset in the middle of SHIFT
      push1(8'h77); push1(8'h88);
      wait_rd1("rs_rd", 10);
      tick(5);
      check_eq("rs_pre_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      check_reset_vals("rs_async");
      tick(1);
      reset_n = 1'b1;
      b = mbits.size();
      wait_words1("rs_done", 16'd1, 30);
      check_word("rs_w", b, 8'h88);

      // Narrow word counter wraps
      enable2 = 1'b1;
      push2(8'h01); push2(8'h02); push2(8'h03); push2(8'h04); push2(8'h05);
      prev2 = words_sent2;
      for (int n = 0; n < 100 && seq.size() < 5; n++) begin
         tick(1);
         if (words_sent2 != prev2) begin
            seq.push_back(words_sent2);
            prev2 = words_sent2;
         end
      end
      check_eq("wrap_n", seq.size(), 5);
      check_eq("wrap_0", seq[0], 1);
      check_eq("wrap_1", seq[1], 2);
      check_eq("wrap_2", seq[2], 3);
      check_eq("wrap_3", seq[3], 0);
      check_eq("wrap_4", seq[4], 1);
      tick(15);
      check_eq("wrap_busy", busy2, 0);
      check_eq("wrap_valid", ser_valid2, 0);
      check_eq("wrap_last", ser_last2, 0);
      check_eq("wrap_data", ser_data2, 0);
      check_eq("pop_empty", pop_empty_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
